// File: rtl/ramb4_s4_arbiter.sv
// Two-requester round-robin arbiter in front of a 1024x4 single-port block RAM.
// After reset (optionally) and on a CLR_START pulse it sweeps the whole array
// with CLEAR_VALUE; otherwise it grants at most one access per cycle and
// returns read data one cycle after the grant.
module ramb4_s4_arbiter #(
    parameter int                    ADDR_WIDTH     = 10,
    parameter int                    DATA_WIDTH     = 4,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CLR_START,
    output logic                  BUSY,

    input  logic                  A_REQ,
    input  logic                  A_WE,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [DATA_WIDTH-1:0] A_DI,
    output logic                  A_GNT,
    output logic                  A_VALID,
    output logic [DATA_WIDTH-1:0] A_DO,

    input  logic                  B_REQ,
    input  logic                  B_WE,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] B_DI,
    output logic                  B_GNT,
    output logic                  B_VALID,
    output logic [DATA_WIDTH-1:0] B_DO,

    output logic                  RAM_EN,
    output logic                  RAM_WE,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [DATA_WIDTH-1:0] RAM_DI,
    input  logic [DATA_WIDTH-1:0] RAM_DO
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    state_t                  cur_st;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    rr_q, rr_d;      // 0: A wins a tie, 1: B wins a tie
    logic                    a_vld_q, a_vld_d;
    logic                    b_vld_q, b_vld_d;
    logic                    win_a, win_b;

    // Next-state, grant and RAM-drive decode; everything is idle while RST is high.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        a_vld_d  = 1'b0;
        b_vld_d  = 1'b0;
        win_a    = 1'b0;
        win_b    = 1'b0;
        BUSY     = 1'b0;
        A_GNT    = 1'b0;
        B_GNT    = 1'b0;
        RAM_EN   = 1'b0;
        RAM_WE   = 1'b0;
        RAM_ADDR = cnt_q;
        RAM_DI   = CLEAR_VALUE;

        // The RESET encoding only lives in the register; the first cycle after
        // release already behaves as the post-reset state so no cycle is lost.
        cur_st = state_q;
        if (state_q == ST_RESET) begin
            if (CLEAR_ON_RESET) cur_st = ST_CLEAR;
            else                cur_st = ST_SERVE;
        end

        if (!RST) begin
            case (cur_st)
                ST_CLEAR: begin
                    BUSY     = 1'b1;
                    RAM_EN   = 1'b1;
                    RAM_WE   = 1'b1;
                    RAM_ADDR = cnt_q;
                    RAM_DI   = CLEAR_VALUE;
                    // Counter wraps to 0 naturally after the last address.
                    cnt_d    = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_SERVE;
                    else                             state_d = ST_CLEAR;
                end
                ST_SERVE: begin
                    win_b = B_REQ & (~A_REQ | rr_q);
                    win_a = A_REQ & ~win_b;
                    A_GNT = win_a;
                    B_GNT = win_b;
                    if (win_a || win_b) begin
                        RAM_EN   = 1'b1;
                        RAM_WE   = win_b ? B_WE   : A_WE;
                        RAM_ADDR = win_b ? B_ADDR : A_ADDR;
                        RAM_DI   = win_b ? B_DI   : A_DI;
                        // Pointer moves to whoever lost (or did not ask).
                        rr_d     = win_a;
                    end
                    a_vld_d = win_a & ~A_WE;
                    b_vld_d = win_b & ~B_WE;
                    // A grant in this cycle still completes before the sweep.
                    if (CLR_START) state_d = ST_CLEAR;
                    else           state_d = ST_SERVE;
                end
                default: ;
            endcase
        end
    end

    // State, sweep counter, round-robin pointer and read-valid registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            a_vld_q <= a_vld_d;
            b_vld_q <= b_vld_d;
        end
    end

    // Read data comes straight from the RAM; a reset cycle masks a pending valid.
    assign A_VALID = a_vld_q & ~RST;
    assign B_VALID = b_vld_q & ~RST;
    assign A_DO    = RAM_DO;
    assign B_DO    = RAM_DO;

endmodule

// File: tb/tb_ramb4_s4_arbiter.sv
// Bench for ramb4_s4_arbiter: two instances (clear-on-reset with 0, and
// no clear-on-reset with 4'hF) behind behavioural RAM models, one active at a time.
module tb_ramb4_s4_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       act;
    logic       rst1, rst2, clr;
    logic       a_req, a_we, b_req, b_we;
    logic [9:0] a_addr, b_addr;
    logic [3:0] a_di, b_di;

    logic       busy1, a_gnt1, a_vld1, b_gnt1, b_vld1, ram_en1, ram_we1;
    logic [3:0] a_do1, b_do1, ram_di1, ram_do1;
    logic [9:0] ram_addr1;
    logic       busy2, a_gnt2, a_vld2, b_gnt2, b_vld2, ram_en2, ram_we2;
    logic [3:0] a_do2, b_do2, ram_di2, ram_do2;
    logic [9:0] ram_addr2;

    ramb4_s4_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(4), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(4'h0)) u_dut1 (
        .CLK(clk), .RST(rst1), .CLR_START(clr), .BUSY(busy1),
        .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_DI(a_di),
        .A_GNT(a_gnt1), .A_VALID(a_vld1), .A_DO(a_do1),
        .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_DI(b_di),
        .B_GNT(b_gnt1), .B_VALID(b_vld1), .B_DO(b_do1),
        .RAM_EN(ram_en1), .RAM_WE(ram_we1), .RAM_ADDR(ram_addr1),
        .RAM_DI(ram_di1), .RAM_DO(ram_do1));

    ramb4_s4_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(4), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(4'hF)) u_dut2 (
        .CLK(clk), .RST(rst2), .CLR_START(clr), .BUSY(busy2),
        .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_DI(a_di),
        .A_GNT(a_gnt2), .A_VALID(a_vld2), .A_DO(a_do2),
        .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_DI(b_di),
        .B_GNT(b_gnt2), .B_VALID(b_vld2), .B_DO(b_do2),
        .RAM_EN(ram_en2), .RAM_WE(ram_we2), .RAM_ADDR(ram_addr2),
        .RAM_DI(ram_di2), .RAM_DO(ram_do2));

    // Behavioural RAMB4_S4: synchronous read, write-first.
    logic [3:0] mem1 [1024];
    logic [3:0] mem2 [1024];
    always @(posedge clk) begin
        if (ram_en1) begin
            if (ram_we1) begin mem1[ram_addr1] <= ram_di1; ram_do1 <= ram_di1; end
            else ram_do1 <= mem1[ram_addr1];
        end
        if (ram_en2) begin
            if (ram_we2) begin mem2[ram_addr2] <= ram_di2; ram_do2 <= ram_di2; end
            else ram_do2 <= mem2[ram_addr2];
        end
    end

    // Outputs of whichever instance is under test.
    logic       o_busy, o_a_gnt, o_a_vld, o_b_gnt, o_b_vld, o_en, o_we;
    logic [3:0] o_a_do, o_b_do, o_di;
    logic [9:0] o_addr;
    assign o_busy  = act ? busy2     : busy1;
    assign o_a_gnt = act ? a_gnt2    : a_gnt1;
    assign o_a_vld = act ? a_vld2    : a_vld1;
    assign o_a_do  = act ? a_do2     : a_do1;
    assign o_b_gnt = act ? b_gnt2    : b_gnt1;
    assign o_b_vld = act ? b_vld2    : b_vld1;
    assign o_b_do  = act ? b_do2     : b_do1;
    assign o_en    = act ? ram_en2   : ram_en1;
    assign o_we    = act ? ram_we2   : ram_we1;
    assign o_addr  = act ? ram_addr2 : ram_addr1;
    assign o_di    = act ? ram_di2   : ram_di1;

    typedef struct {
        int         due;
        bit         is_b;
        logic [3:0] d;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] shadow [1024];
    bit         m_serve;
    int         m_cnt;
    bit         m_rr;
    int         tcyc;
    int         n_tests;
    int         n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, tcyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check every output against the model, advance the model.
    task automatic step(input bit r, input bit c,
                        input bit ar, input bit aw, input logic [9:0] aa, input logic [3:0] ad,
                        input bit br, input bit bw, input logic [9:0] ba, input logic [3:0] bd);
        bit         ga, gb, va, vb, cor, wwe;
        logic [3:0] da, db, cv;
        exp_t       e;
        cor = !act;
        cv  = act ? 4'hF : 4'h0;
        @(negedge clk);
        rst1 = act ? 1'b1 : r;
        rst2 = act ? r : 1'b1;
        clr = c; a_req = ar; a_we = aw; a_addr = aa; a_di = ad;
        b_req = br; b_we = bw; b_addr = ba; b_di = bd;
        #1;
        va = 0; vb = 0; da = '0; db = '0;
        if (sb.size() > 0 && sb[0].due == tcyc) begin
            e = sb.pop_front();
            if (!r) begin
                if (e.is_b) begin vb = 1; db = e.d; end
                else        begin va = 1; da = e.d; end
            end
        end
        chk("a_valid", o_a_vld, va);
        chk("b_valid", o_b_vld, vb);
        if (va) chk("a_do", o_a_do, da);
        if (vb) chk("b_do", o_b_do, db);

        ga = 0; gb = 0;
        if (!r && m_serve) begin
            if (ar && br) begin ga = !m_rr; gb = m_rr; end
            else          begin ga = ar;    gb = br;   end
        end
        chk("a_gnt", o_a_gnt, ga);
        chk("b_gnt", o_b_gnt, gb);
        chk("busy", o_busy, !r && !m_serve);
        if (!r && !m_serve) begin
            chk("sweep_en", o_en, 1);
            chk("sweep_we", o_we, 1);
            chk("sweep_addr", o_addr, m_cnt);
            chk("sweep_di", o_di, cv);
        end else if (ga || gb) begin
            wwe = ga ? aw : bw;
            chk("ram_en", o_en, 1);
            chk("ram_we", o_we, wwe);
            chk("ram_addr", o_addr, ga ? aa : ba);
            if (wwe) chk("ram_di", o_di, ga ? ad : bd);
        end else begin
            chk("ram_en_idle", o_en, 0);
            chk("ram_we_idle", o_we, 0);
        end

        if (r) begin
            m_serve = !cor; m_cnt = 0; m_rr = 0;
        end else if (!m_serve) begin
            m_cnt++;
            if (m_cnt == 1024) begin
                m_cnt = 0; m_serve = 1;
                foreach (shadow[i]) shadow[i] = cv;
            end
        end else begin
            if (ga) begin
                if (aw) shadow[aa] = ad;
                else sb.push_back('{due: tcyc + 1, is_b: 1'b0, d: shadow[aa]});
                m_rr = 1;
            end
            if (gb) begin
                if (bw) shadow[ba] = bd;
                else sb.push_back('{due: tcyc + 1, is_b: 1'b1, d: shadow[ba]});
                m_rr = 0;
            end
            if (c) m_serve = 0;
        end
        tcyc++;
    endtask

    task automatic idle(input int n, input bit r);
        repeat (n) step(r, 0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; tcyc = 0;
        m_serve = 0; m_cnt = 0; m_rr = 0;
        act = 1'b0; rst1 = 1'b1; rst2 = 1'b1; clr = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_di = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_di = '0;
        foreach (shadow[i]) shadow[i] = 4'h0;

        // Instance 1: reset, then a full sweep with both requesters waiting for reads.
        idle(3, 1);
        repeat (1024 + 6) step(0, 0, 1, 0, 10'h001, 4'h0, 1, 0, 10'h002, 4'h0);
        idle(2, 0);

        // Single requester: write then read the top address on consecutive cycles.
        step(0, 0, 1, 1, 10'h3FF, 4'h5, 0, 0, '0, '0);
        step(0, 0, 1, 0, 10'h3FF, 4'h0, 0, 0, '0, '0);
        idle(2, 0);

        // Contention with distinct data: both write, then both read back.
        repeat (2) step(0, 0, 1, 1, 10'h020, 4'h7, 1, 1, 10'h021, 4'h9);
        repeat (2) step(0, 0, 1, 0, 10'h020, 4'h0, 1, 0, 10'h021, 4'h0);
        idle(2, 0);

        // B reads 0x010 in the CLR_START cycle; A waits through the sweep.
        step(0, 0, 0, 0, '0, '0, 1, 1, 10'h010, 4'hA);
        step(0, 1, 0, 0, '0, '0, 1, 0, 10'h010, 4'h0);
        for (int i = 0; i < 1026; i++)
            step(0, (i == 100), 1, 0, 10'h020, 4'h0, 0, 0, '0, '0);
        idle(2, 0);

        // Reset in the middle of a sweep restarts it from address 0.
        step(0, 1, 0, 0, '0, '0, 0, 0, '0, '0);
        for (int i = 0; i < 600 && m_cnt != 'h200; i++) idle(1, 0);
        idle(2, 1);
        idle(1024 + 2, 0);
        step(0, 0, 1, 0, 10'h3FF, 4'h0, 0, 0, '0, '0);
        idle(2, 0);

        // Instance 2: no sweep after reset, clear value 4'hF on command.
        act = 1'b1;
        sb.delete();
        idle(2, 1);
        step(0, 0, 1, 1, 10'h3FF, 4'h3, 0, 0, '0, '0);
        idle(1, 0);
        step(0, 1, 0, 0, '0, '0, 0, 0, '0, '0);
        idle(1024, 0);
        step(0, 0, 1, 0, 10'h000, 4'h0, 0, 0, '0, '0);
        step(0, 0, 1, 0, 10'h3FF, 4'h0, 0, 0, '0, '0);
        idle(2, 0);
        // A read followed immediately by reset: its valid must be suppressed.
        step(0, 0, 0, 0, '0, '0, 1, 0, 10'h3FF, 4'h0);
        idle(1, 1);
        idle(2, 0);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
